// File: rtl/anycore_l15_reqarb_pkg.sv
// Shared L1.5 request definitions: request-type and size codes, FSM states and helpers
// used by the anycore-to-L1.5 request arbiter.
package anycore_l15_reqarb_pkg;

    localparam int PHY_ADDR_WIDTH = 40;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [4:0] IMISS_RQ = 5'b10000;

    localparam logic [2:0] MSG_DATA_SIZE_1B  = 3'b001;
    localparam logic [2:0] MSG_DATA_SIZE_2B  = 3'b010;
    localparam logic [2:0] MSG_DATA_SIZE_4B  = 3'b011;
    localparam logic [2:0] MSG_DATA_SIZE_8B  = 3'b100;
    localparam logic [2:0] MSG_DATA_SIZE_16B = 3'b101;
    localparam logic [2:0] MSG_DATA_SIZE_32B = 3'b110;

    // Line alignment for ifill (32B) and load (16B) requests
    localparam logic [PHY_ADDR_WIDTH-1:0] IC_ADDR_MASK = 40'hFF_FFFF_FFE0;
    localparam logic [PHY_ADDR_WIDTH-1:0] LD_ADDR_MASK = 40'hFF_FFFF_FFF0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;

    typedef enum logic [1:0] {
        SRC_IC = 2'd0,
        SRC_LD = 2'd1,
        SRC_ST = 2'd2
    } src_e;

    function automatic logic [63:0] byte_swap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [2:0] st_size_code(input logic [1:0] s);
        logic [2:0] c;
        case (s)
            2'd0:    c = MSG_DATA_SIZE_1B;
            2'd1:    c = MSG_DATA_SIZE_2B;
            2'd2:    c = MSG_DATA_SIZE_4B;
            2'd3:    c = MSG_DATA_SIZE_8B;
            default: c = MSG_DATA_SIZE_8B;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/anycore_l15_reqarb_if.sv
// Request channel from the transducer to the L1.5: registered request fields plus ack.
interface anycore_l15_reqarb_if;
    import anycore_l15_reqarb_pkg::*;

    logic                      val;
    logic [4:0]                rqtype;
    logic [2:0]                size;
    logic [PHY_ADDR_WIDTH-1:0] address;
    logic [63:0]               data;
    logic                      nc;
    logic                      threadid;
    logic                      ack;

    modport master (output val, rqtype, size, address, data, nc, threadid, input ack);
    modport slave  (input val, rqtype, size, address, data, nc, threadid, output ack);
endinterface

// File: rtl/anycore_l15_reqslot.sv
// One pending-request slot: a set captures the payload unless the slot is already
// occupied and not being cleared in the same cycle; set beats clear.
module anycore_l15_reqslot #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_i,
    input  logic         clr_i,
    input  logic [W-1:0] payload_i,
    output logic         pend_o,
    output logic [W-1:0] payload_o
);
    logic         pend_q, pend_d;
    logic [W-1:0] payload_q, payload_d;

    // Next-state: capture on accepted set, otherwise honour clear
    always_comb begin
        pend_d    = pend_q;
        payload_d = payload_q;
        if (set_i && (!pend_q || clr_i)) begin
            pend_d    = 1'b1;
            payload_d = payload_i;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= 1'b0;
            payload_q <= {W{1'b0}};
        end else begin
            pend_q    <= pend_d;
            payload_q <= payload_d;
        end
    end

    assign pend_o    = pend_q;
    assign payload_o = payload_q;
endmodule

// File: rtl/anycore_l15_reqarb.sv
// Arbitrates anycore ifill/load/store misses onto a single-outstanding L1.5 request channel.
// Optional response timeout flag is built when ANYCORE_L15_REQ_TIMEOUT_EN is defined.
module anycore_l15_reqarb
    import anycore_l15_reqarb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      anycore_ic2mem_reqvalid_i,
    input  logic [PHY_ADDR_WIDTH-1:0] anycore_ic2mem_reqaddr_i,
    input  logic                      anycore_dc2mem_ldvalid_i,
    input  logic [PHY_ADDR_WIDTH-1:0] anycore_dc2mem_ldaddr_i,
    input  logic                      anycore_dc2mem_stvalid_i,
    input  logic [PHY_ADDR_WIDTH-1:0] anycore_dc2mem_staddr_i,
    input  logic [63:0]               anycore_dc2mem_stdata_i,
    input  logic [1:0]                anycore_dc2mem_stsize_i,
    input  logic                      anycore_mem2ic_respvalid_i,
    input  logic                      anycore_mem2dc_ldvalid_i,
    input  logic                      anycore_mem2dc_stcomplete_i,
    anycore_l15_reqarb_if.master      l15,
    output logic                      timeout_err_o
);
    localparam int ST_W = PHY_ADDR_WIDTH + 64 + 2;

    logic [1:0]                state_q, state_d;
    src_e                      sel_q, sel_d;
    logic                      val_q, val_d;
    logic [4:0]                rqtype_q, rqtype_d;
    logic [2:0]                size_q, size_d;
    logic [PHY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]               data_q, data_d;

    logic                      ic_pend_s, ld_pend_s, st_pend_s;
    logic                      ic_clr_s, ld_clr_s, st_clr_s, done_s;
    logic [PHY_ADDR_WIDTH-1:0] ic_addr_s, ld_addr_s;
    logic [ST_W-1:0]           st_payload_s;

    // Only the completion of the outstanding source can retire it
    assign ic_clr_s = (state_q == ST_WAIT_RESP) && (sel_q == SRC_IC) && anycore_mem2ic_respvalid_i;
    assign ld_clr_s = (state_q == ST_WAIT_RESP) && (sel_q == SRC_LD) && anycore_mem2dc_ldvalid_i;
    assign st_clr_s = (state_q == ST_WAIT_RESP) && (sel_q == SRC_ST) && anycore_mem2dc_stcomplete_i;
    assign done_s   = ic_clr_s | ld_clr_s | st_clr_s;

    anycore_l15_reqslot #(.W(PHY_ADDR_WIDTH)) u_slot_ic (
        .clk(clk), .rst(rst), .set_i(anycore_ic2mem_reqvalid_i), .clr_i(ic_clr_s),
        .payload_i(anycore_ic2mem_reqaddr_i & IC_ADDR_MASK), .pend_o(ic_pend_s), .payload_o(ic_addr_s)
    );
    anycore_l15_reqslot #(.W(PHY_ADDR_WIDTH)) u_slot_ld (
        .clk(clk), .rst(rst), .set_i(anycore_dc2mem_ldvalid_i), .clr_i(ld_clr_s),
        .payload_i(anycore_dc2mem_ldaddr_i & LD_ADDR_MASK), .pend_o(ld_pend_s), .payload_o(ld_addr_s)
    );
    anycore_l15_reqslot #(.W(ST_W)) u_slot_st (
        .clk(clk), .rst(rst), .set_i(anycore_dc2mem_stvalid_i), .clr_i(st_clr_s),
        .payload_i({anycore_dc2mem_staddr_i, anycore_dc2mem_stdata_i, anycore_dc2mem_stsize_i}),
        .pend_o(st_pend_s), .payload_o(st_payload_s)
    );

    // FSM next-state and request field load on selection
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        val_d    = val_q;
        rqtype_d = rqtype_q;
        size_d   = size_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (st_pend_s) begin
                    state_d  = ST_ISSUE;
                    val_d    = 1'b1;
                    sel_d    = SRC_ST;
                    rqtype_d = STORE_RQ;
                    size_d   = st_size_code(st_payload_s[1:0]);
                    addr_d   = st_payload_s[ST_W-1 -: PHY_ADDR_WIDTH];
                    data_d   = byte_swap64(st_payload_s[65:2]);
                end else if (ld_pend_s) begin
                    state_d  = ST_ISSUE;
                    val_d    = 1'b1;
                    sel_d    = SRC_LD;
                    rqtype_d = LOAD_RQ;
                    size_d   = MSG_DATA_SIZE_16B;
                    addr_d   = ld_addr_s;
                    data_d   = 64'h0;
                end else if (ic_pend_s) begin
                    state_d  = ST_ISSUE;
                    val_d    = 1'b1;
                    sel_d    = SRC_IC;
                    rqtype_d = IMISS_RQ;
                    size_d   = MSG_DATA_SIZE_32B;
                    addr_d   = ic_addr_s;
                    data_d   = 64'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (l15.ack) begin
                    state_d = ST_WAIT_RESP;
                    val_d   = 1'b0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_RESP: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                val_d   = 1'b0;
            end
        endcase
    end

    // FSM and request output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= SRC_IC;
            val_q    <= 1'b0;
            rqtype_q <= 5'd0;
            size_q   <= 3'd0;
            addr_q   <= {PHY_ADDR_WIDTH{1'b0}};
            data_q   <= 64'h0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
            rqtype_q <= rqtype_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign l15.val      = val_q;
    assign l15.rqtype   = rqtype_q;
    assign l15.size     = size_q;
    assign l15.address  = addr_q;
    assign l15.data     = data_q;
    assign l15.nc       = 1'b0;
    assign l15.threadid = 1'b0;

`ifdef ANYCORE_L15_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Counter restarts on each WAIT_RESP entry and saturates at the limit
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if ((state_q == ST_ISSUE) && l15.ack) begin
            cnt_d = {CW{1'b0}};
        end else if ((state_q == ST_WAIT_RESP) && (cnt_q != TC)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if ((state_q == ST_WAIT_RESP) && (cnt_d == TC)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Timeout counter and sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err_o = err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: doc/anycore_l15_reqarb.md
ANYCORE_L15_REQARB -- requirements
Module: anycore_l15_reqarb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: cycles in WAIT_RESP before timeout_err sets (used only with the Configuration macro).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 anycore_ic2mem_reqvalid  in  1  icache miss pulse.
REQ-005 anycore_ic2mem_reqaddr  in  PHY_ADDR_WIDTH(40)  icache miss address.
REQ-006 anycore_dc2mem_ldvalid  in  1  dcache load-miss pulse.
REQ-007 anycore_dc2mem_ldaddr  in  40  load address.
REQ-008 anycore_dc2mem_stvalid  in  1  dcache store pulse.
REQ-009 anycore_dc2mem_staddr  in  40  store address.
REQ-010 anycore_dc2mem_stdata  in  64  store data, anycore byte order.
REQ-011 anycore_dc2mem_stsize  in  2  log2 of store bytes (0=1B .. 3=8B).
REQ-012 anycore_mem2ic_respvalid  in  1  ifill completion from the L1.5 response encoder.
REQ-013 anycore_mem2dc_ldvalid  in  1  load completion from the encoder.
REQ-014 anycore_mem2dc_stcomplete  in  1  store completion from the encoder.
REQ-015 transducer_l15_val  out  1  request valid to L1.5.
REQ-016 transducer_l15_rqtype  out  5  request type (`IMISS_RQ`/`LOAD_RQ`/`STORE_RQ`).
REQ-017 transducer_l15_size  out  3  L1.5 size code.
REQ-018 transducer_l15_address  out  40  request address.
REQ-019 transducer_l15_data  out  64  store data, L1.5 byte order.
REQ-020 transducer_l15_nc / transducer_l15_threadid  out  1 each  tied 0.
REQ-021 l15_transducer_ack  in  1  L1.5 accepts the current request.
REQ-022 timeout_err  out  1  sticky response-timeout flag.

Function
REQ-023 One pending slot per source (ic, ld, st). A valid pulse sets the slot and captures its address/data/size at the next edge.
REQ-024 A valid pulse to an already-set slot that is not clearing the same cycle is dropped, and the slot contents are unchanged.
REQ-025 A slot is cleared when its own completion pulse arrives in WAIT_RESP. If a set and a clear hit the same slot in the same cycle, the set wins and the new contents are captured.
REQ-026 FSM states are IDLE, ISSUE and WAIT_RESP; one request is outstanding at a time.
REQ-027 IDLE: if any slot is set, select by fixed priority st > ld > ic, latch the selection and go to ISSUE next cycle.
REQ-028 ISSUE: transducer_l15_val=1 with all fields registered and stable until l15_transducer_ack. On ack, go to WAIT_RESP next cycle. Ack in the first ISSUE cycle is legal.
REQ-029 WAIT_RESP: val=0. The completion matching the selected source returns the FSM to IDLE next cycle; all other completions are ignored.
REQ-030 Completions arriving in IDLE or ISSUE are ignored.
REQ-031 Latency: a valid pulse in cycle N with the FSM idle and no higher-priority slot set gives val=1 in cycle N+2.
REQ-032 Address: ifill has [4:0] forced to 0; load has [3:0] forced to 0; store address is passed unchanged.
REQ-033 Size: ifill uses the 32B code, load the 16B code, store stsize 0..3 maps to the 1/2/4/8B codes.
REQ-034 Store data is byte-reversed (byte0<->byte7, etc.). Load/ifill data is 0.

Reset
REQ-035 With rst high at an edge: all slots cleared, FSM=IDLE, val=0, rqtype/size/address/data=0, timeout_err=0, counter=0.
REQ-036 Reset mid-operation discards pending and outstanding requests with no completion replay.

Configuration
REQ-037 With ANYCORE_L15_REQ_TIMEOUT_EN defined: a counter clears on entry to WAIT_RESP and increments each WAIT_RESP cycle. When it reaches TIMEOUT_CYCLES, timeout_err sets and holds until reset. The FSM stays in WAIT_RESP.
REQ-038 Without the macro: no counter is built and timeout_err is tied 0; the port still exists.

Structure
REQ-039 Request-type and size codes come from the shared L1.5 define package. No local literals are used.
REQ-040 One sub-module, anycore_l15_reqslot, implements one pending slot (set/clear/capture) and is instantiated three times.

Verification
REQ-041 ld pulse at cycle 10 with addr 0x80_0000_1238 -> val high at 12, rqtype LOAD_RQ, address 0x80_0000_1230, size 16B; ack at 14 -> val low at 15.
REQ-042 st, ld and ic pulses in the same cycle -> issue order st, ld, ic; each is issued only after the prior completion.
REQ-043 st with data 0x0102030405060708 and stsize 3 -> transducer data 0x0807060504030201, 8B code.
REQ-044 stcomplete during a load's WAIT_RESP -> ignored, FSM stays in WAIT_RESP until ldvalid.
REQ-045 rst asserted in ISSUE with all three slots set -> next cycle val=0, IDLE, and no issue afterwards.
REQ-046 With macro defined and TIMEOUT_CYCLES=8, no completion after ack -> timeout_err=1 eight WAIT_RESP cycles after entry, remains 1.
